// File: rtl/dmni_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dmni_mem_arbiter
//
// Shares the PE's single-port local data memory between the CPU data port and
// the DMNI DMA memory interface. Arbitration is round-robin with a burst
// limit: an owner keeps the memory for at most BURST_MAX consecutive granted
// cycles while the other side is waiting, then ownership is forced over.
// Grants are combinational, so one access per cycle is sustained and an
// owner switch costs no idle cycle.
//
// Parameters:
//   BURST_MAX  max consecutive grants to one owner under contention (1..255)
//   DMA_FIRST  1: DMA wins contention with no history, 0: CPU wins
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   cpu_req/we/addr/data_i             CPU request (we == 0 is a read)
//   cpu_gnt_o, cpu_rvalid_o, cpu_data_o  CPU accept, read valid, read data
//   dma_req/we/addr/data_i             DMA request (we == 0 is a read)
//   dma_gnt_o, dma_rvalid_o, dma_data_o  DMA accept, read valid, read data
//   mem_en/we/addr/data_o              memory macro controls and write data
//   mem_data_i                         memory read data (1-cycle latency)
//
// Optional build macro DMNI_ARB_STATS_EN adds:
//   stat_clr_i        synchronous clear of the three counters
//   stat_cpu_stall_o  cycles the CPU requested but was not granted
//   stat_dma_stall_o  cycles the DMA requested but was not granted
//   stat_switch_o     owner switches forced by the burst limit
// -----------------------------------------------------------------------------
module dmni_mem_arbiter #(
    parameter int BURST_MAX = 8,
    parameter int DMA_FIRST = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cpu_req_i,
    input  logic [3:0]  cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic        cpu_gnt_o,
    output logic        cpu_rvalid_o,
    output logic [31:0] cpu_data_o,
    input  logic        dma_req_i,
    input  logic [3:0]  dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_data_i,
    output logic        dma_gnt_o,
    output logic        dma_rvalid_o,
    output logic [31:0] dma_data_o,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
`ifdef DMNI_ARB_STATS_EN
    ,
    input  logic        stat_clr_i,
    output logic [31:0] stat_cpu_stall_o,
    output logic [31:0] stat_dma_stall_o,
    output logic [31:0] stat_switch_o
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } state_e;

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    state_e     state_q, state_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       cpu_rvalid_q, cpu_rvalid_d;
    logic       dma_rvalid_q, dma_rvalid_d;

    logic       cpu_win, dma_win;
    logic       forced_switch;
    logic [7:0] cnt_inc;

    // Saturating increment of the run length of the current owner.
    assign cnt_inc = (burst_cnt_q >= BURST_LIM) ? BURST_LIM : burst_cnt_q + 8'd1;

    always_comb begin
        state_d       = IDLE;
        burst_cnt_d   = 8'd0;
        cpu_win       = 1'b0;
        dma_win       = 1'b0;
        forced_switch = 1'b0;
        case ({cpu_req_i, dma_req_i})
            2'b10: begin
                cpu_win     = 1'b1;
                state_d     = OWN_CPU;
                burst_cnt_d = (state_q == OWN_CPU) ? cnt_inc : 8'd1;
            end
            2'b01: begin
                dma_win     = 1'b1;
                state_d     = OWN_DMA;
                burst_cnt_d = (state_q == OWN_DMA) ? cnt_inc : 8'd1;
            end
            2'b11: begin
                if (state_q == IDLE) begin
                    dma_win     = (DMA_FIRST != 0);
                    cpu_win     = (DMA_FIRST == 0);
                    burst_cnt_d = 8'd1;
                end else if (burst_cnt_q < BURST_LIM) begin
                    cpu_win     = (state_q == OWN_CPU);
                    dma_win     = (state_q == OWN_DMA);
                    burst_cnt_d = cnt_inc;
                end else begin
                    // Burst limit reached: hand over to the waiting side.
                    cpu_win       = (state_q == OWN_DMA);
                    dma_win       = (state_q == OWN_CPU);
                    burst_cnt_d   = 8'd1;
                    forced_switch = 1'b1;
                end
                state_d = cpu_win ? OWN_CPU : OWN_DMA;
            end
            default: ;
        endcase
    end

    // Grants are masked by the reset pin so nothing reaches the memory while
    // reset is held, even though the request decode is purely combinational.
    assign cpu_gnt_o = cpu_win & rst_ni;
    assign dma_gnt_o = dma_win & rst_ni;

    always_comb begin
        mem_we_o   = 4'd0;
        mem_addr_o = 32'd0;
        mem_data_o = 32'd0;
        if (cpu_gnt_o) begin
            mem_we_o   = cpu_we_i;
            mem_addr_o = cpu_addr_i;
            mem_data_o = cpu_data_i;
        end else if (dma_gnt_o) begin
            mem_we_o   = dma_we_i;
            mem_addr_o = dma_addr_i;
            mem_data_o = dma_data_i;
        end
    end

    assign mem_en_o = cpu_gnt_o | dma_gnt_o;

    // A granted read returns data one cycle later, tagged to its requester.
    assign cpu_rvalid_d = cpu_gnt_o & (cpu_we_i == 4'd0);
    assign dma_rvalid_d = dma_gnt_o & (dma_we_i == 4'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            burst_cnt_q  <= 8'd0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    assign cpu_rvalid_o = cpu_rvalid_q;
    assign dma_rvalid_o = dma_rvalid_q;
    assign cpu_data_o   = mem_data_i;
    assign dma_data_o   = mem_data_i;

`ifdef DMNI_ARB_STATS_EN
    logic [31:0] stat_cpu_stall_q, stat_cpu_stall_d;
    logic [31:0] stat_dma_stall_q, stat_dma_stall_d;
    logic [31:0] stat_switch_q, stat_switch_d;

    always_comb begin
        stat_cpu_stall_d = stat_cpu_stall_q;
        stat_dma_stall_d = stat_dma_stall_q;
        stat_switch_d    = stat_switch_q;
        if (stat_clr_i) begin
            stat_cpu_stall_d = 32'd0;
            stat_dma_stall_d = 32'd0;
            stat_switch_d    = 32'd0;
        end else begin
            if (cpu_req_i && !cpu_gnt_o) stat_cpu_stall_d = stat_cpu_stall_q + 32'd1;
            if (dma_req_i && !dma_gnt_o) stat_dma_stall_d = stat_dma_stall_q + 32'd1;
            if (forced_switch)           stat_switch_d    = stat_switch_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_cpu_stall_q <= 32'd0;
            stat_dma_stall_q <= 32'd0;
            stat_switch_q    <= 32'd0;
        end else begin
            stat_cpu_stall_q <= stat_cpu_stall_d;
            stat_dma_stall_q <= stat_dma_stall_d;
            stat_switch_q    <= stat_switch_d;
        end
    end

    assign stat_cpu_stall_o = stat_cpu_stall_q;
    assign stat_dma_stall_o = stat_dma_stall_q;
    assign stat_switch_o    = stat_switch_q;
`endif

endmodule
